// File: rtl/osc_freq_meter_if.sv
// Port bundle for osc_freq_meter: oscillator input, measurement request and
// the registered result with its flags.
interface osc_freq_meter_if #(
   parameter int CNT_W = 16
);
   // valid is a one-cycle pulse with no backpressure. count, inrange, ovf and
   // stuck change only on the valid cycle and hold until the next pulse.
   // start is level-sampled and honoured only while the meter is idle.
   logic             osc;
   logic             start;
   logic             busy;
   logic             valid;
   logic [CNT_W-1:0] count;
   logic             inrange;
   logic             ovf;
   logic             stuck;
   logic [1:0]       state_dbg;

   modport master (
      output osc, start,
      input  busy, valid, count, inrange, ovf, stuck, state_dbg
   );

   modport slave (
      input  osc, start,
      output busy, valid, count, inrange, ovf, stuck, state_dbg
   );
endinterface

// File: rtl/osc_freq_meter.sv
// Frequency meter: counts synchronized OSC rising edges over a fixed window
// of clk cycles, then reports the count with range, overflow and stuck flags.
module osc_freq_meter #(
   parameter int GATE_CYCLES  = 1000,
   parameter int CNT_W        = 16,
   parameter int MIN_CNT      = 24,
   parameter int MAX_CNT      = 26,
   parameter int STUCK_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rstn,
   osc_freq_meter_if.slave  m
);
   localparam int GATE_W = $clog2(GATE_CYCLES);
   localparam int GAP_W  = $clog2(STUCK_CYCLES + 1);

   localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GAP_W-1:0]  STUCK_V   = GAP_W'(STUCK_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_CNT);
   localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GATE = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic              s1, s2, prev;
   logic [1:0]        warm;
   logic              osc_rise;
   logic [CNT_W-1:0]  edge_cnt;
   logic [GATE_W-1:0] gate_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              ovf_q, stuck_q;
   logic              busy_q, valid_q, inrange_q, ovf_o, stuck_o;
   logic [CNT_W-1:0]  count_q;

   // Two-flop synchronizer plus history flop; warm-up masks the spurious
   // rise seen when OSC is already high as the flops leave reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
         warm <= 2'd0;
      end else begin
         s1   <= m.osc;
         s2   <= s1;
         prev <= s2;
         if (warm != 2'd3) warm <= warm + 2'd1;
      end
   end

   assign osc_rise = s2 & ~prev & (warm == 2'd3);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (m.start) state_nx = GATE;
         GATE:    if (gate_cnt == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         edge_cnt  <= '0;
         gate_cnt  <= '0;
         gap_cnt   <= '0;
         ovf_q     <= 1'b0;
         stuck_q   <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         count_q   <= '0;
         inrange_q <= 1'b0;
         ovf_o     <= 1'b0;
         stuck_o   <= 1'b0;
      end else begin
         // busy trails the state by one cycle so it covers the idle turnaround
         busy_q  <= (state != IDLE);
         valid_q <= (state == DONE);
         case (state)
            IDLE: begin
               if (m.start) begin
                  edge_cnt <= '0;
                  gate_cnt <= GATE_LOAD;
                  gap_cnt  <= '0;
                  ovf_q    <= 1'b0;
                  stuck_q  <= 1'b0;
               end
            end
            GATE: begin
               if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
               if (osc_rise) begin
                  gap_cnt <= '0;
                  if (edge_cnt == CNT_MAX) ovf_q <= 1'b1;
                  else                     edge_cnt <= edge_cnt + 1'b1;
               end else if (gap_cnt != STUCK_V) begin
                  gap_cnt <= gap_cnt + 1'b1;
                  if (gap_cnt == STUCK_V - 1'b1) stuck_q <= 1'b1;
               end
            end
            DONE: begin
               count_q   <= edge_cnt;
               ovf_o     <= ovf_q;
               stuck_o   <= stuck_q;
               inrange_q <= (edge_cnt >= MIN_C) && (edge_cnt <= MAX_C);
            end
            default: ;
         endcase
      end
   end

   assign m.busy      = busy_q;
   assign m.valid     = valid_q;
   assign m.count     = count_q;
   assign m.inrange   = inrange_q;
   assign m.ovf       = ovf_o;
   assign m.stuck     = stuck_o;
   assign m.state_dbg = state;
endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: a 16-bit and a 4-bit instance share OSC and START;
// an edge-time model predicts every output, and directed cases pin the model.
module tb_osc_freq_meter;
   localparam int G     = 1000;
   localparam int STK   = 256;
   localparam int MINC  = 24;
   localparam int MAXC  = 26;
   localparam int W_W   = 16;
   localparam int W_N   = 4;

   // clock / reset block
   logic clk = 1'b0;
   logic rstn;
   logic start;
   logic osc;
   always #5 clk = ~clk;

   osc_freq_meter_if #(.CNT_W(W_W)) bw ();
   osc_freq_meter_if #(.CNT_W(W_N)) bn ();
   assign bw.osc = osc;
   assign bw.start = start;
   assign bn.osc = osc;
   assign bn.start = start;

   osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(W_W), .MIN_CNT(MINC), .MAX_CNT(MAXC),
                    .STUCK_CYCLES(STK))
      dut_w (.clk(clk), .rstn(rstn), .m(bw));
   osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(W_N), .MIN_CNT(MINC), .MAX_CNT(MAXC),
                    .STUCK_CYCLES(STK))
      dut_n (.clk(clk), .rstn(rstn), .m(bn));

   int vectors = 0;
   int miscompares = 0;
   int printed = 0;

   task automatic cmp(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         if (printed < 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
         printed++;
      end
   endtask

   task automatic cmp_rng(input string name, input longint act, input longint lo, input longint hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         if (printed < 40) $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
         printed++;
      end
   endtask

   // oscillator source; every rising edge time is recorded for the model
   int  osc_half = 200;
   time rises[$];
   initial begin
      osc = 1'b0;
      #3;
      forever begin
         if (osc_half == 0) begin
            osc = 1'b0;
            wait (osc_half != 0);
         end else begin
            #(osc_half);
            if (osc_half == 0) osc = 1'b0;
            else begin
               osc = ~osc;
               if (osc) rises.push_back($time);
            end
         end
      end
   end

   // behavioural model: window = G clk periods from the accepting edge
   int  cyc = 0;
   bit  has_win = 0;
   int  open_c = 0;
   time open_t = 0;
   bit  exp_busy = 0;
   logic [31:0] exp_q[$];
   int  exp_lo[2], exp_hi[2], exp_ovf[2];
   int  exp_stuck = 0;
   int  min_t[2], max_t[2], maxv[2];

   initial begin
      maxv[0] = (1 << W_W) - 1;
      maxv[1] = (1 << W_N) - 1;
      for (int i = 0; i < 2; i++) begin
         min_t[i] = MINC % (maxv[i] + 1);
         max_t[i] = MAXC % (maxv[i] + 1);
         exp_lo[i] = 0; exp_hi[i] = 0; exp_ovf[i] = 0;
      end
   end

   function automatic void finish_window();
      time t_close = open_t + time'(G) * 10;
      time last = open_t;
      time gapmax = 0;
      int  raw = 0;
      int  gap_cyc;
      foreach (rises[k]) begin
         if (rises[k] >= open_t && rises[k] < t_close) begin
            raw++;
            if (rises[k] - last > gapmax) gapmax = rises[k] - last;
            last = rises[k];
         end
      end
      if (t_close - last > gapmax) gapmax = t_close - last;
      gap_cyc = int'(gapmax / 10);
      for (int i = 0; i < 2; i++) begin
         exp_lo[i] = (raw - 1 < 0) ? 0 : raw - 1;
         if (exp_lo[i] > maxv[i]) exp_lo[i] = maxv[i];
         exp_hi[i] = (raw + 1 > maxv[i]) ? maxv[i] : raw + 1;
         exp_ovf[i] = (raw - 1 > maxv[i]) ? 1 : ((raw + 1 <= maxv[i]) ? 0 : 2);
      end
      exp_stuck = (gap_cyc >= STK + 5) ? 1 : ((gap_cyc <= STK - 5) ? 0 : 2);
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rstn) begin
         has_win = 0;
         exp_busy = 0;
         exp_q.delete();
         for (int i = 0; i < 2; i++) begin
            exp_lo[i] = 0; exp_hi[i] = 0; exp_ovf[i] = 0;
         end
         exp_stuck = 0;
      end else begin
         if (has_win && cyc == open_c + G + 1) finish_window();
         if (start && (!has_win || cyc >= open_c + G + 2)) begin
            has_win = 1;
            open_c = cyc;
            open_t = $time;
            exp_q.push_back(cyc + G + 1);
            while (rises.size() > 0 && rises[0] + 2000 < $time) void'(rises.pop_front());
         end
         exp_busy = has_win && (cyc >= open_c + 1) && (cyc <= open_c + G + 1);
      end
   end

   // scoreboard: compare both instances on every falling edge
   task automatic check_dut(input int i, input bit v, input bit b, input int c,
                            input bit ir, input bit o, input bit s, input bit ev);
      string p = (i == 0) ? "w" : "n";
      cmp({p, "_valid"}, v, ev);
      cmp({p, "_busy"}, b, exp_busy);
      cmp_rng({p, "_count"}, c, exp_lo[i], exp_hi[i]);
      cmp({p, "_inrange"}, ir, (c >= min_t[i] && c <= max_t[i]));
      if (exp_ovf[i] != 2) cmp({p, "_ovf"}, o, exp_ovf[i]);
      if (exp_stuck != 2) cmp({p, "_stuck"}, s, exp_stuck);
   endtask

   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            ev = (exp_q.size() > 0 && exp_q[0] == cyc);
            check_dut(0, bw.valid, bw.busy, int'(bw.count), bw.inrange, bw.ovf, bw.stuck, ev);
            check_dut(1, bn.valid, bn.busy, int'(bn.count), bn.inrange, bn.ovf, bn.stuck, ev);
            if (ev) void'(exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic pulse_start(output int n);
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #1 n = cyc; #1 start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int vc, output bit ok);
      ok = 1'b0;
      vc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bw.valid) begin
            ok = 1'b1;
            vc = cyc;
            break;
         end
      end
   endtask

   task automatic run_window(input string tag);
      int n, vc;
      bit ok;
      pulse_start(n);
      wait_valid(G + 20, vc, ok);
      cmp({tag, "_valid_seen"}, ok, 1);
      if (ok) cmp({tag, "_latency"}, vc - n, G + 1);
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   initial begin
      int n, vc, np, first;
      int vcs[3];
      bit ok;
      rstn = 1'b0;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rstn = 1'b1;
      @(negedge clk);
      cmp("reset_busy", bw.busy, 0);
      cmp("reset_valid", bw.valid, 0);
      cmp("reset_count", bw.count, 0);
      cmp("reset_flags", {bw.inrange, bw.ovf, bw.stuck}, 0);
      cmp("reset_state", bw.state_dbg, 0);
      idle(5);

      // 2.5 MHz nominal
      run_window("nom");
      cmp_rng("nom_count", bw.count, 24, 26);
      cmp("nom_inrange", bw.inrange, 1);
      cmp("nom_ovf", bw.ovf, 0);
      cmp("nom_stuck", bw.stuck, 0);
      cmp("nom4_count", bn.count, 15);
      cmp("nom4_ovf", bn.ovf, 1);
      cmp("nom4_inrange", bn.inrange, 0);
      idle(3);

      // 10 MHz
      osc_half = 50;
      run_window("fast");
      cmp_rng("fast_count", bw.count, 99, 101);
      cmp("fast_inrange", bw.inrange, 0);
      idle(3);

      // stopped oscillator, then recovery
      osc_half = 0;
      idle(10);
      run_window("dead");
      cmp("dead_count", bw.count, 0);
      cmp("dead_stuck", bw.stuck, 1);
      cmp("dead_inrange", bw.inrange, 0);
      cmp("dead4_ovf", bn.ovf, 0);
      osc_half = 200;
      idle(10);
      run_window("back");
      cmp("back_stuck", bw.stuck, 0);
      cmp_rng("back_count", bw.count, 24, 26);
      idle(3);

      // reset in the middle of a window
      pulse_start(n);
      idle(499);
      rstn = 1'b0;
      idle(1);
      rstn = 1'b1;
      @(negedge clk);
      cmp("abort_busy", bw.busy, 0);
      cmp("abort_count", bw.count, 0);
      cmp("abort_flags", {bw.inrange, bw.ovf, bw.stuck}, 0);
      cmp("abort_state", bw.state_dbg, 0);
      np = 0;
      for (int i = 0; i < G + 20; i++) begin
         @(negedge clk);
         if (bw.valid) np++;
      end
      cmp("abort_no_valid", np, 0);
      idle(2);
      run_window("after_abort");
      cmp_rng("after_abort_count", bw.count, 24, 26);
      idle(3);

      // START while busy is ignored
      pulse_start(n);
      idle(298);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      np = 0;
      first = -1;
      for (int i = 0; i < G + 200; i++) begin
         @(negedge clk);
         if (bw.valid) begin
            np++;
            if (first < 0) first = cyc;
         end
      end
      cmp("busy_start_pulses", np, 1);
      cmp("busy_start_latency", first - n, G + 1);
      idle(3);

      // START held high: back-to-back windows
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid(G + 20, vc, ok);
         cmp("held_valid_seen", ok, 1);
         vcs[k] = vc;
      end
      start = 1'b0;
      cmp("held_period_a", vcs[1] - vcs[0], G + 2);
      cmp("held_period_b", vcs[2] - vcs[1], G + 2);
      idle(5);

      // randomized windows checked by the model
      for (int r = 0; r < 10; r++) begin
         int mode;
         mode = $urandom_range(0, 3);
         osc_half = (mode == 1) ? 0 : $urandom_range(20, 300);
         idle($urandom_range(4, 30));
         @(posedge clk); #2 start = 1'b1;
         idle($urandom_range(1, 4));
         start = 1'b0;
         if (mode == 2) begin
            idle($urandom_range(100, 800));
            osc_half = 0;
         end
         wait_valid(G + 20, vc, ok);
         cmp("rand_valid_seen", ok, 1);
      end
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/osc_freq_meter.md
# osc_freq_meter

Synthesizable frequency meter for the on-chip oscillator output (OSCE OSC pin), clocked from a known system clock. It gates a fixed window of CLK cycles, counts OSC rising edges inside that window, and reports the count with range and stuck-oscillator flags. It sits between the internal oscillator and the configuration/health logic, which uses the result to confirm NOM_FREQ before trusting OSC-derived timing.

## Interface
- GATE_CYCLES, 1000: length of the measurement window in CLK cycles (≥ 2).
- CNT_W, 16: width of COUNT.
- MIN_CNT, 24: lowest COUNT for which INRANGE is asserted.
- MAX_CNT, 26: highest COUNT for which INRANGE is asserted.
- STUCK_CYCLES, 256: CLK cycles without an OSC edge, inside the window, that flag STUCK.

- CLK  input  1  system clock. This is the only clock. Its frequency must exceed 2× the OSC frequency.
- RSTN  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- OSC  input  1  oscillator under test. Asynchronous to CLK.
- START  input  1  request a measurement. Level-sampled; acted on only in IDLE.
- BUSY  output  1  high while a window is open.
- VALID  output  1  one-cycle pulse when COUNT and the flags update.
- COUNT  output  CNT_W  OSC rising edges counted in the last window. Saturating.
- INRANGE  output  1  MIN_CNT ≤ COUNT ≤ MAX_CNT for the last window.
- OVF  output  1  the edge counter saturated in the last window.
- STUCK  output  1  an edge gap ≥ STUCK_CYCLES occurred in the last window.

## Operation
- Synchronizer and edge detect:
  - OSC passes through two flops, then a third "previous" flop.
  - An edge is counted when sync = 1 and prev = 0.
  - All three flops reset to 0.
  - A 2-bit warm-up counter suppresses edge reporting for the first 3 CLK cycles after RSTN deasserts.
- FSM states: IDLE, GATE, DONE.
  - IDLE → GATE when START = 1.
    - Edge counter clears to 0.
    - Gate counter loads GATE_CYCLES−1.
    - Gap counter clears.
    - Internal stuck flag clears.
  - GATE: each cycle, the edge counter increments on a detected edge, saturating at 2^CNT_W−1. Saturation sets the internal overflow flag.
    - The gap counter increments on each cycle with no edge and clears on an edge.
    - When the gap counter reaches STUCK_CYCLES, the internal stuck flag sets and holds.
    - The gate counter decrements. Its terminal cycle is the cycle it equals 0, and an edge detected in that cycle is counted.
    - Gate counter = 0 → DONE.
  - DONE → IDLE unconditionally, after one cycle. In the DONE cycle:
    - COUNT, OVF and STUCK load from the internal registers.
    - INRANGE loads the range comparison, evaluated on the final count.
    - VALID = 1.
- BUSY = 1 in GATE and DONE.
- START while BUSY is ignored. It is not queued.
- Holding START high re-arms immediately. This gives back-to-back windows with one IDLE cycle between them.
- Outputs hold their values between VALID pulses.
- Range compare is unsigned and CNT_W bits wide. If MIN_CNT > MAX_CNT, INRANGE is never set.

## Timing
- Reset values:
  - BUSY = 0, VALID = 0, COUNT = 0, INRANGE = 0, OVF = 0, STUCK = 0.
  - FSM = IDLE.
  - All internal counters and flags = 0.
- RSTN low at any point, including mid-window, aborts the window. It produces no VALID pulse and restores the reset values on the next edge.
- OSC-to-count latency: 3 CLK cycles from the OSC rising edge to the edge-counter increment.
  - Edges within 3 cycles of window open or close can shift by one.
  - Expected accuracy is ±1 count.
- START sampled high at edge n gives:
  - BUSY = 1 from edge n+1.
  - VALID high for the cycle after edge n+GATE_CYCLES+1.
  - BUSY = 0 after edge n+GATE_CYCLES+2.
- A window is exactly GATE_CYCLES CLK cycles long.
- No output is combinational from OSC or START.

## Test plan
- CLK 10 ns, OSC 400 ns period (2.5 MHz), defaults, START pulse → VALID after 1001 cycles, COUNT ∈ {24, 25, 26}, INRANGE = 1, OVF = 0, STUCK = 0.
- OSC 100 ns period (10 MHz) → COUNT ∈ {99, 100, 101}, INRANGE = 0.
- OSC held at 0 → COUNT = 0, STUCK = 1, INRANGE = 0. Then restore 2.5 MHz and START again → STUCK = 0, COUNT ≈ 25.
- CNT_W = 4, OSC 2.5 MHz → COUNT = 15, OVF = 1, INRANGE = 0.
- RSTN low for 1 cycle at cycle 500 of a window → no VALID pulse, all outputs 0, FSM = IDLE. A new START then completes normally.
- START pulsed again at cycle 300 of a window → ignored: exactly one VALID, timed from the first START. START held high → VALID pulses every GATE_CYCLES+2 cycles.
